// File: rtl/dnpcie_aurora_pkg.sv
// Shared types and beat-word layout for the Aurora RX frame buffer.
// Buffer words are {tlast, tkeep[0:3], tdata[0:31]}.
package dnpcie_aurora_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RX,
        WAIT_CRC,
        DISCARD
    } wr_state_t;

    localparam int TLAST_BIT = 36;
    localparam int TKEEP_LSB = 32;
    localparam int BEAT_W    = 37;

endpackage

// File: rtl/dnpcie_aurora_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// Read data holds its value while re is low.
module dnpcie_aurora_sdp_ram #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 37
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/dnpcie_aurora_rx_frame_buffer.sv
// Store-and-forward RX frame buffer: frames are released to m_axis only
// after a CRC-pass verdict; anything else is rolled back to the last commit.
module dnpcie_aurora_rx_frame_buffer
    import dnpcie_aurora_pkg::*;
#(
    parameter int ADDR_WIDTH = 9,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 aclk,
    input  logic                 reset,
    input  logic                 channel_up,
    input  logic [0:31]          s_axis_tdata,
    input  logic [0:3]           s_axis_tkeep,
    input  logic                 s_axis_tvalid,
    input  logic                 s_axis_tlast,
    input  logic                 s_axis_crc_valid,
    input  logic                 s_axis_crc_pass_fail_n,
    input  logic                 s_axis_length_err,
    output logic [0:31]          m_axis_tdata,
    output logic [0:3]           m_axis_tkeep,
    output logic                 m_axis_tvalid,
    output logic                 m_axis_tlast,
    input  logic                 m_axis_tready,
    output logic [CNT_WIDTH-1:0] frames_ok,
    output logic [CNT_WIDTH-1:0] frames_drop_crc,
    output logic [CNT_WIDTH-1:0] frames_drop_ovf
);

    localparam int PW = ADDR_WIDTH + 1;
    localparam logic [PW-1:0] DEPTH_P = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [PW-1:0] ONE     = {{ADDR_WIDTH{1'b0}}, 1'b1};

    wr_state_t             state_q, state_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         commit_q, commit_d;
    logic [PW-1:0]         rd_ptr_q;
    logic                  we, accept, verdict_free, crc_ok;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [BEAT_W-1:0]     wdata;
    logic                  ok_inc, crc_inc;
    logic [1:0]            ovf_inc;

    logic                  avail, ren, pop, out_vld;
    logic                  ram_vld_q, skid_vld_q, ram_left, skid_left;
    logic [BEAT_W-1:0]     ram_q, skid_q, out_word;

    function automatic logic [CNT_WIDTH-1:0] sat_add(
        input logic [CNT_WIDTH-1:0] c,
        input logic [1:0]           inc
    );
        logic [CNT_WIDTH:0] s;
        s = {1'b0, c} + {{(CNT_WIDTH-1){1'b0}}, inc};
        return s[CNT_WIDTH] ? '1 : s[CNT_WIDTH-1:0];
    endfunction

    assign crc_ok = s_axis_crc_pass_fail_n & ~s_axis_length_err;
    assign wdata  = {s_axis_tlast, s_axis_tkeep, s_axis_tdata};

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        commit_d     = commit_q;
        accept       = 1'b0;
        verdict_free = 1'b1;
        we           = 1'b0;
        waddr        = '0;
        ok_inc       = 1'b0;
        crc_inc      = 1'b0;
        ovf_inc      = 2'd0;

        unique case (state_q)
            IDLE: accept = s_axis_tvalid & channel_up;
            RX: begin
                if (!channel_up) begin
                    wr_ptr_d = commit_q;
                    ovf_inc  = 2'd1;
                    state_d  = IDLE;
                end else begin
                    accept = s_axis_tvalid;
                end
            end
            WAIT_CRC: begin
                verdict_free = 1'b0;
                if (!channel_up) begin
                    wr_ptr_d = commit_q;
                    ovf_inc  = 2'd1;
                    state_d  = IDLE;
                end else begin
                    if (s_axis_crc_valid) begin
                        if (crc_ok) begin
                            commit_d = wr_ptr_q;
                            ok_inc   = 1'b1;
                        end else begin
                            wr_ptr_d = commit_q;
                            crc_inc  = 1'b1;
                        end
                        state_d = IDLE;
                    end else if (s_axis_tvalid) begin
                        // beat without verdict: old frame is lost
                        wr_ptr_d = commit_q;
                        ovf_inc  = 2'd1;
                        state_d  = IDLE;
                    end
                    accept = s_axis_tvalid;
                end
            end
            DISCARD: begin
                if (!channel_up || (s_axis_tvalid && s_axis_tlast)) begin
                    wr_ptr_d = commit_q;
                    ovf_inc  = 2'd1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // accepted beat is placed relative to the pointers after any verdict
        if (accept) begin
            if (wr_ptr_d - rd_ptr_q == DEPTH_P) begin
                if (s_axis_tlast) begin
                    wr_ptr_d = commit_d;
                    ovf_inc  = ovf_inc + 2'd1;
                    state_d  = IDLE;
                end else begin
                    state_d = DISCARD;
                end
            end else begin
                we       = 1'b1;
                waddr    = wr_ptr_d[ADDR_WIDTH-1:0];
                wr_ptr_d = wr_ptr_d + ONE;
                if (!s_axis_tlast) begin
                    state_d = RX;
                end else if (s_axis_crc_valid && verdict_free) begin
                    if (crc_ok) begin
                        commit_d = wr_ptr_d;
                        ok_inc   = 1'b1;
                    end else begin
                        wr_ptr_d = commit_d;
                        crc_inc  = 1'b1;
                    end
                    state_d = IDLE;
                end else begin
                    state_d = WAIT_CRC;
                end
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (reset) begin
            state_q         <= IDLE;
            wr_ptr_q        <= '0;
            commit_q        <= '0;
            frames_ok       <= '0;
            frames_drop_crc <= '0;
            frames_drop_ovf <= '0;
        end else begin
            state_q         <= state_d;
            wr_ptr_q        <= wr_ptr_d;
            commit_q        <= commit_d;
            frames_ok       <= sat_add(frames_ok, {1'b0, ok_inc});
            frames_drop_crc <= sat_add(frames_drop_crc, {1'b0, crc_inc});
            frames_drop_ovf <= sat_add(frames_drop_ovf, ovf_inc);
        end
    end

    dnpcie_aurora_sdp_ram #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(BEAT_W)
    ) u_ram (
        .clk  (aclk),
        .we   (we),
        .waddr(waddr),
        .wdata(wdata),
        .re   (ren),
        .raddr(rd_ptr_q[ADDR_WIDTH-1:0]),
        .rdata(ram_q)
    );

    // RAM output register is the younger slot, skid the older one
    assign avail     = rd_ptr_q != commit_q;
    assign out_vld   = skid_vld_q | ram_vld_q;
    assign pop       = out_vld & m_axis_tready;
    assign ram_left  = ram_vld_q & ~(pop & ~skid_vld_q);
    assign skid_left = skid_vld_q & ~pop;
    assign ren       = avail & ~(ram_left & skid_left);

    always_ff @(posedge aclk) begin
        if (reset) begin
            rd_ptr_q   <= '0;
            ram_vld_q  <= 1'b0;
            skid_vld_q <= 1'b0;
            skid_q     <= '0;
        end else begin
            if (ren) rd_ptr_q <= rd_ptr_q + ONE;
            ram_vld_q <= ren | ram_left;
            if (ren && ram_left) begin
                skid_q     <= ram_q;
                skid_vld_q <= 1'b1;
            end else begin
                skid_vld_q <= skid_left;
            end
        end
    end

    always_comb begin
        out_word = '0;
        if (skid_vld_q)     out_word = skid_q;
        else if (ram_vld_q) out_word = ram_q;
    end

    assign m_axis_tvalid = out_vld;
    assign m_axis_tdata  = out_word[TKEEP_LSB-1:0];
    assign m_axis_tkeep  = out_word[TLAST_BIT-1:TKEEP_LSB];
    assign m_axis_tlast  = out_word[TLAST_BIT];

endmodule

// File: tb/tb_dnpcie_aurora_rx_frame_buffer.sv
// Scoreboard bench: frames that should commit are queued beat by beat,
// a negedge monitor pops and compares every m_axis handshake.
module tb_dnpcie_aurora_rx_frame_buffer;
    import dnpcie_aurora_pkg::*;

    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int CW    = 16;

    logic          aclk = 1'b0;
    logic          reset;
    logic          channel_up;
    logic [0:31]   s_axis_tdata;
    logic [0:3]    s_axis_tkeep;
    logic          s_axis_tvalid;
    logic          s_axis_tlast;
    logic          s_axis_crc_valid;
    logic          s_axis_crc_pass_fail_n;
    logic          s_axis_length_err;
    logic [0:31]   m_axis_tdata;
    logic [0:3]    m_axis_tkeep;
    logic          m_axis_tvalid;
    logic          m_axis_tlast;
    logic          m_axis_tready;
    logic [CW-1:0] frames_ok;
    logic [CW-1:0] frames_drop_crc;
    logic [CW-1:0] frames_drop_ovf;

    int            tests = 0;
    int            fails = 0;
    logic [36:0]   exp_q[$];
    int            m_ok = 0;
    int            m_crc = 0;
    int            m_ovf = 0;
    int            m_wr = 0;
    bit            rand_ready = 0;
    bit            stalled = 0;
    logic [36:0]   held;

    dnpcie_aurora_rx_frame_buffer #(
        .ADDR_WIDTH(AW),
        .CNT_WIDTH (CW)
    ) dut (
        .aclk                  (aclk),
        .reset                 (reset),
        .channel_up            (channel_up),
        .s_axis_tdata          (s_axis_tdata),
        .s_axis_tkeep          (s_axis_tkeep),
        .s_axis_tvalid         (s_axis_tvalid),
        .s_axis_tlast          (s_axis_tlast),
        .s_axis_crc_valid      (s_axis_crc_valid),
        .s_axis_crc_pass_fail_n(s_axis_crc_pass_fail_n),
        .s_axis_length_err     (s_axis_length_err),
        .m_axis_tdata          (m_axis_tdata),
        .m_axis_tkeep          (m_axis_tkeep),
        .m_axis_tvalid         (m_axis_tvalid),
        .m_axis_tlast          (m_axis_tlast),
        .m_axis_tready         (m_axis_tready),
        .frames_ok             (frames_ok),
        .frames_drop_crc       (frames_drop_crc),
        .frames_drop_ovf       (frames_drop_ovf)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge aclk) begin
        logic [36:0] got;
        logic [36:0] e;
        got = {m_axis_tlast, m_axis_tkeep, m_axis_tdata};
        if (reset) begin
            stalled = 0;
        end else begin
            if (stalled) begin
                check("stall_valid", 64'(m_axis_tvalid), 64'd1);
                check("stall_payload", 64'(got), 64'(held));
            end
            if (m_axis_tvalid && m_axis_tready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_beat: got %h expected none", got);
                end else begin
                    e = exp_q.pop_front();
                    check("beat", 64'(got), 64'(e));
                end
                stalled = 0;
            end else begin
                stalled = m_axis_tvalid;
                held    = got;
            end
        end
    end

    initial forever begin
        @(posedge aclk);
        #1;
        if (rand_ready) m_axis_tready = 1'($urandom_range(0, 1));
    end

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic drive_idle();
        s_axis_tvalid          = 1'b0;
        s_axis_tlast           = 1'b0;
        s_axis_crc_valid       = 1'b0;
        s_axis_crc_pass_fail_n = 1'b0;
        s_axis_length_err      = 1'b0;
    endtask

    task automatic set_verdict(input bit pass, input bit lenerr);
        s_axis_crc_valid       = 1'b1;
        s_axis_crc_pass_fail_n = pass;
        s_axis_length_err      = lenerr;
    endtask

    // vdelay: 0 = verdict on tlast beat, n>0 = n cycles later, <0 = none
    task automatic send_frame(input int len, input logic [31:0] base,
                              input int vdelay, input bit pass,
                              input bit lenerr, input bit gaps);
        logic [36:0] beats[$];
        bit          good;
        good = pass && !lenerr;
        for (int i = 0; i < len; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                drive_idle();
                step();
            end
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = base + 32'(i);
            s_axis_tkeep  = (i == len - 1) ? 4'($urandom_range(1, 15)) : 4'hF;
            s_axis_tlast  = (i == len - 1);
            beats.push_back({s_axis_tlast, s_axis_tkeep, s_axis_tdata});
            if (i == len - 1 && vdelay == 0) begin
                set_verdict(pass, lenerr);
                if (good) foreach (beats[j]) exp_q.push_back(beats[j]);
            end
            step();
            drive_idle();
        end
        if (vdelay > 0) begin
            repeat (vdelay - 1) step();
            set_verdict(pass, lenerr);
            if (good) foreach (beats[j]) exp_q.push_back(beats[j]);
            step();
            drive_idle();
        end
        if (vdelay >= 0) begin
            if (good) begin
                m_ok++;
                m_wr += len;
            end else begin
                m_crc++;
            end
        end
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            step();
            n++;
        end
        repeat (4) step();
        check(name, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic check_counters(input string tag);
        check({tag, "_ok"}, 64'(frames_ok), 64'(m_ok));
        check({tag, "_crc"}, 64'(frames_drop_crc), 64'(m_crc));
        check({tag, "_ovf"}, 64'(frames_drop_ovf), 64'(m_ovf));
    endtask

    initial begin
        int len;
        int kind;
        int n;
        reset         = 1'b1;
        channel_up    = 1'b1;
        s_axis_tdata  = '0;
        s_axis_tkeep  = '0;
        m_axis_tready = 1'b1;
        drive_idle();
        repeat (3) step();
        reset = 1'b0;
        @(negedge aclk);
        check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("rst_tdata", 64'(m_axis_tdata), 64'd0);
        check_counters("rst");
        step();

        // 1: basic pass, verdict one cycle after tlast, 2-cycle latency
        send_frame(4, 32'h1, 1, 1, 0, 0);
        @(negedge aclk);
        check("lat_t1", 64'(m_axis_tvalid), 64'd0);
        step();
        @(negedge aclk);
        check("lat_t2", 64'(m_axis_tvalid), 64'd1);
        step();
        wait_drain("t1_drain");
        check_counters("t1");

        // 2: CRC failure rolls back
        send_frame(3, 32'h200, 1, 0, 0, 0);
        repeat (6) step();
        check("t2_wr_ptr", 64'(dut.wr_ptr_q), 64'(m_wr % (2 * DEPTH)));
        check_counters("t2");

        // 3: overflow with reader stalled
        m_axis_tready = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = 32'h300 + 32'(i);
            s_axis_tkeep  = 4'hF;
            s_axis_tlast  = (i == 20);
            step();
            if (i == 16) check("t3_rx16", 64'(dut.state_q), 64'(RX));
            if (i == 17) check("t3_disc17", 64'(dut.state_q), 64'(DISCARD));
        end
        drive_idle();
        m_ovf++;
        step();
        check_counters("t3a");
        send_frame(4, 32'h400, 2, 1, 0, 0);
        repeat (3) step();
        m_axis_tready = 1'b1;
        wait_drain("t3_drain");
        check_counters("t3b");

        // 4: channel down mid-frame
        for (int i = 0; i < 2; i++) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = 32'h500 + 32'(i);
            s_axis_tkeep  = 4'hF;
            step();
        end
        drive_idle();
        channel_up = 1'b0;
        step();
        channel_up = 1'b1;
        m_ovf++;
        step();
        send_frame(5, 32'h550, 0, 1, 0, 0);
        wait_drain("t4_drain");
        check_counters("t4");

        // 5: back-to-back frames, random backpressure
        rand_ready = 1;
        send_frame(8, 32'h600, 0, 1, 0, 0);
        send_frame(8, 32'h700, 0, 1, 0, 0);
        wait_drain("t5_drain");
        check_counters("t5");

        // protocol error: new frame before verdict
        send_frame(2, 32'h800, -1, 1, 0, 0);
        m_ovf++;
        send_frame(3, 32'h900, 1, 1, 0, 0);
        wait_drain("t7_drain");
        check_counters("t7");

        // 6: reset with committed unread frames
        rand_ready = 0;
        step();
        m_axis_tready = 1'b0;
        send_frame(3, 32'hA00, 0, 1, 0, 0);
        send_frame(3, 32'hB00, 1, 1, 0, 0);
        repeat (3) step();
        reset = 1'b1;
        exp_q.delete();
        m_ok  = 0;
        m_crc = 0;
        m_ovf = 0;
        m_wr  = 0;
        step();
        reset = 1'b0;
        @(negedge aclk);
        check("t6_tvalid", 64'(m_axis_tvalid), 64'd0);
        check_counters("t6");
        step();

        // randomized frames; sizing keeps the buffer from filling
        rand_ready = 1;
        for (int f = 0; f < 40; f++) begin
            len = $urandom_range(1, 8);
            n   = 0;
            while (exp_q.size() + len > DEPTH && n < 500) begin
                step();
                n++;
            end
            kind = $urandom_range(0, 9);
            send_frame(len, 32'h1000 * (f + 1), $urandom_range(0, 3),
                       kind >= 2, kind == 9, 1);
            repeat ($urandom_range(0, 2)) step();
        end
        rand_ready = 0;
        step();
        m_axis_tready = 1'b1;
        wait_drain("rand_drain");
        check_counters("rand");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
